dcache_replace: RTL and testbench
=================================

Name: dcache_replace

Overview:
- Miss-handling victim-selection stage of the dcache.
- Accepts a miss request, reads the set's 8-bit dirty vector through the dirty-array replace port, and selects a victim way.
- If the victim is dirty, issues a writeback request for it first.
- Then issues a fill request naming index, way and new tag. The fill stage later clears the dirty bit through its own dirty-array port.

Parameters:
- TAG_W, 20, width of the miss/fill tag.
- INDEX_W, 6, set index width. The dirty-array port is 6 bits, so only 6 is legal.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- miss_valid  in  1  miss request valid
- miss_ready  out  1  request accepted (high only in IDLE)
- miss_index  in  INDEX_W  set index of the miss
- miss_tag  in  TAG_W  tag of the missing line
- replace2dirty_array_valid  out  1  dirty-array read strobe
- replace2dirty_array_index  out  INDEX_W  dirty-array read address
- replace2dirty_array_ready  out  1  releases the dirty-array output holder
- dirty_array2replace_rdata  in  8  dirty vector, bit n = way n
- replace2wb_valid  out  1  writeback request valid
- wb2replace_ready  in  1  writeback stage accepts
- replace2wb_index  out  INDEX_W  victim set
- replace2wb_way  out  3  victim way
- replace2fill_valid  out  1  fill request valid
- fill2replace_ready  in  1  fill stage accepts
- replace2fill_index  out  INDEX_W  fill set
- replace2fill_way  out  3  fill way
- replace2fill_tag  out  TAG_W  new tag
- hit_valid  in  1  cache hit notification (used only by the optional PLRU)
- hit_index  in  INDEX_W  hit set
- hit_way  in  3  hit way
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0, except miss_ready = 1. State = IDLE, round-robin pointer rr_ptr = 0, request registers = 0.
- FSM states: IDLE, READ, DECIDE, WB_REQ, FILL_REQ.
- IDLE:
  - miss_ready = 1.
  - On miss_valid, latch index and tag, then go to READ.
- READ (exactly 1 cycle):
  - replace2dirty_array_valid = 1, index = latched index.
  - Go to DECIDE.
  - The single-cycle strobe is required: the dirty array gives replace priority over hit_write/fill, so a longer strobe would starve them.
- DECIDE (1 cycle):
  - replace2dirty_array_ready = 1.
  - Sample rdata and compute victim v: rr_ptr, or PLRU if the optional feature is enabled.
  - If rdata[v] = 1, go to WB_REQ; otherwise go to FILL_REQ.
- WB_REQ:
  - replace2wb_valid = 1 with the latched index and v.
  - Outputs held stable until wb2replace_ready; on the handshake, go to FILL_REQ.
- FILL_REQ:
  - replace2fill_valid = 1 with the index, v and tag.
  - On fill2replace_ready, return to IDLE and advance the replacement state.
- Valid/ready rules:
  - A transfer occurs on a cycle where both valid and ready are high.
  - valid is never withdrawn before the handshake.
  - The handshake cycle clears valid on the next edge.
- Latency:
  - Miss handshake at cycle T → dirty read at T+1 → decide at T+2 → first wb/fill valid at T+3.
  - A clean miss with ready tied high completes at T+3; the next miss is accepted at T+4.
- Round-robin:
  - rr_ptr is 3 bits, incremented by 1 on each fill handshake; wraps 7→0.
  - It is global, not per-set.
- Victim v is latched in DECIDE and never recomputed mid-request.
- Reset mid-operation: asynchronously return to IDLE and clear all outputs. The in-flight miss is dropped; the requester must reissue it.
- hit_* inputs are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: DCACHE_REPLACE_PLRU_EN.
- When defined, per-set 7-bit tree PLRU (64×7 flops, reset 0) replaces rr_ptr.
  - Tree layout: node0 is the root; node1/node2 are the left (ways 0-3) and right (ways 4-7) subtrees; nodes 3-6 select between way pairs.
  - Bit = 0 means descend left; the victim is found by following the bits.
  - On access to way w, set each node on w's path to point away from w.
  - Updates occur on hit_valid (hit_index, hit_way) and on the fill handshake (latched index, v).
  - If both occur the same cycle for the same set, apply the hit update first, then the fill update.
- When not defined, round-robin as above, and no PLRU storage exists.

Test Plan:
- Clean miss: reset; miss index 5, tag 0x1234; rdata 0x00; both readies high → dirty read at T+1 with index 5; fill valid at T+3 with way 0, index 5, tag 0x1234; no wb valid; rr_ptr = 1.
- Dirty victim: rr_ptr = 1, rdata 0x02 → wb valid with index and way 1; after the wb handshake, fill with way 1.
- Backpressure: hold wb2replace_ready low for 3 cycles → replace2wb_* stable, fill valid stays 0, busy = 1, miss_ready = 0.
- Wrap: 9 consecutive clean misses → victims 0,1,…,7,0.
- Reset asserted during WB_REQ → all valids drop immediately, miss_ready = 1; the next miss is served normally.
- Macro defined: hit index 3 way 0, then miss index 3 → victim way 4. A second miss to index 3 (after the fill to way 4) → victim way 2.

Source files
------------

// File: rtl/dcache_replace.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_replace                                               |
// | Description : Dcache miss victim selection. Reads the set's dirty vector,  |
// |               picks a victim way, issues a writeback when the victim is    |
// |               dirty, then issues the fill request (index, way, new tag).   |
// |               Optional macro DCACHE_REPLACE_PLRU_EN swaps the global       |
// |               round-robin pointer for a per-set 7-bit tree PLRU.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dcache_replace #(
    parameter int TAG_W   = 20,
    parameter int INDEX_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               miss_valid,
    output logic               miss_ready,
    input  logic [INDEX_W-1:0] miss_index,
    input  logic [TAG_W-1:0]   miss_tag,
    output logic               replace2dirty_array_valid,
    output logic [INDEX_W-1:0] replace2dirty_array_index,
    output logic               replace2dirty_array_ready,
    input  logic [7:0]         dirty_array2replace_rdata,
    output logic               replace2wb_valid,
    input  logic               wb2replace_ready,
    output logic [INDEX_W-1:0] replace2wb_index,
    output logic [2:0]         replace2wb_way,
    output logic               replace2fill_valid,
    input  logic               fill2replace_ready,
    output logic [INDEX_W-1:0] replace2fill_index,
    output logic [2:0]         replace2fill_way,
    output logic [TAG_W-1:0]   replace2fill_tag,
    input  logic               hit_valid,
    input  logic [INDEX_W-1:0] hit_index,
    input  logic [2:0]         hit_way,
    output logic               busy
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_READ     = 3'd1;
    localparam logic [2:0] c_ST_DECIDE   = 3'd2;
    localparam logic [2:0] c_ST_WB_REQ   = 3'd3;
    localparam logic [2:0] c_ST_FILL_REQ = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [INDEX_W-1:0] r_index;
    logic [TAG_W-1:0]   r_tag;
    logic [2:0]         r_way;
    logic [2:0]         w_victim;
    logic               w_miss_hs;
    logic               w_fill_hs;

    assign w_miss_hs = (r_state == c_ST_IDLE) && miss_valid;
    assign w_fill_hs = (r_state == c_ST_FILL_REQ) && fill2replace_ready;

    // State register; reset drops any in-flight miss immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: READ and DECIDE are single-cycle by construction.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:     if (miss_valid) w_state_nxt = c_ST_READ;
            c_ST_READ:     w_state_nxt = c_ST_DECIDE;
            c_ST_DECIDE:   w_state_nxt = dirty_array2replace_rdata[w_victim] ? c_ST_WB_REQ
                                                                             : c_ST_FILL_REQ;
            c_ST_WB_REQ:   if (wb2replace_ready) w_state_nxt = c_ST_FILL_REQ;
            c_ST_FILL_REQ: if (fill2replace_ready) w_state_nxt = c_ST_IDLE;
            default:       w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Request registers; the victim is frozen in DECIDE for the whole request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_index <= '0;
            r_tag   <= '0;
            r_way   <= '0;
        end else begin
            if (w_miss_hs) begin
                r_index <= miss_index;
                r_tag   <= miss_tag;
            end
            if (r_state == c_ST_DECIDE) r_way <= w_victim;
        end
    end

`ifdef DCACHE_REPLACE_PLRU_EN
    // Tree layout: bit0 root, bit1/bit2 left/right halves, bits3..6 way pairs.
    // A 0 bit descends left; a touch points every node on the path away.
    function automatic logic [6:0] f_plru_touch(input logic [6:0] bits, input logic [2:0] way);
        logic [6:0] v_b;
        v_b    = bits;
        v_b[0] = ~way[2];
        if (way[2]) v_b[2] = ~way[1];
        else        v_b[1] = ~way[1];
        case (way[2:1])
            2'd0:    v_b[3] = ~way[0];
            2'd1:    v_b[4] = ~way[0];
            2'd2:    v_b[5] = ~way[0];
            default: v_b[6] = ~way[0];
        endcase
        return v_b;
    endfunction

    function automatic logic [2:0] f_plru_victim(input logic [6:0] bits);
        logic [2:0] v_w;
        v_w[2] = bits[0];
        v_w[1] = v_w[2] ? bits[2] : bits[1];
        case (v_w[2:1])
            2'd0:    v_w[0] = bits[3];
            2'd1:    v_w[0] = bits[4];
            2'd2:    v_w[0] = bits[5];
            default: v_w[0] = bits[6];
        endcase
        return v_w;
    endfunction

    logic [6:0] r_plru [2**INDEX_W];
    logic [6:0] w_plru_fill_base;

    assign w_victim = f_plru_victim(r_plru[r_index]);

    // A same-set hit in the fill cycle is folded in before the fill touch.
    always_comb begin
        w_plru_fill_base = r_plru[r_index];
        if (hit_valid && (hit_index == r_index))
            w_plru_fill_base = f_plru_touch(r_plru[r_index], hit_way);
    end

    // PLRU storage: hit touches, then fill touch (later write wins on same set).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**INDEX_W; i++) r_plru[i] <= '0;
        end else begin
            if (hit_valid) r_plru[hit_index] <= f_plru_touch(r_plru[hit_index], hit_way);
            if (w_fill_hs) r_plru[r_index] <= f_plru_touch(w_plru_fill_base, r_way);
        end
    end
`else
    logic [2:0] r_rr_ptr;
    logic       w_unused_hit;

    assign w_victim     = r_rr_ptr;
    assign w_unused_hit = &{1'b0, hit_valid, hit_index, hit_way};

    // Global round-robin pointer, advanced once per completed fill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          r_rr_ptr <= '0;
        else if (w_fill_hs) r_rr_ptr <= r_rr_ptr + 3'd1;
    end
`endif

    assign miss_ready                = (r_state == c_ST_IDLE);
    assign busy                      = (r_state != c_ST_IDLE);
    assign replace2dirty_array_valid = (r_state == c_ST_READ);
    assign replace2dirty_array_index = r_index;
    assign replace2dirty_array_ready = (r_state == c_ST_DECIDE);
    assign replace2wb_valid          = (r_state == c_ST_WB_REQ);
    assign replace2wb_index          = r_index;
    assign replace2wb_way            = r_way;
    assign replace2fill_valid        = (r_state == c_ST_FILL_REQ);
    assign replace2fill_index        = r_index;
    assign replace2fill_way          = r_way;
    assign replace2fill_tag          = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_dcache_replace.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dcache_replace                                            |
// | Description : Directed vector bench for dcache_replace (round-robin build, |
// |               or PLRU build when DCACHE_REPLACE_PLRU_EN is defined).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dcache_replace;

    logic        clock = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic        miss_ready;
    logic [5:0]  miss_index;
    logic [19:0] miss_tag;
    logic        dv, dr;
    logic [5:0]  di;
    logic [7:0]  rdata;
    logic        wb_valid, wb_ready;
    logic [5:0]  wb_index;
    logic [2:0]  wb_way;
    logic        fill_valid, fill_ready;
    logic [5:0]  fill_index;
    logic [2:0]  fill_way;
    logic [19:0] fill_tag;
    logic        hit_valid;
    logic [5:0]  hit_index;
    logic [2:0]  hit_way;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    dcache_replace #(.TAG_W(20), .INDEX_W(6)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .miss_valid                (miss_valid),
        .miss_ready                (miss_ready),
        .miss_index                (miss_index),
        .miss_tag                  (miss_tag),
        .replace2dirty_array_valid (dv),
        .replace2dirty_array_index (di),
        .replace2dirty_array_ready (dr),
        .dirty_array2replace_rdata (rdata),
        .replace2wb_valid          (wb_valid),
        .wb2replace_ready          (wb_ready),
        .replace2wb_index          (wb_index),
        .replace2wb_way            (wb_way),
        .replace2fill_valid        (fill_valid),
        .fill2replace_ready        (fill_ready),
        .replace2fill_index        (fill_index),
        .replace2fill_way          (fill_way),
        .replace2fill_tag          (fill_tag),
        .hit_valid                 (hit_valid),
        .hit_index                 (hit_index),
        .hit_way                   (hit_way),
        .busy                      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full miss, starting and ending at a negedge. The writeback stage is
    // held off for 'stall' extra cycles when the victim is dirty.
    task automatic do_miss(input logic [5:0] idx, input logic [19:0] tag, input logic [7:0] rd,
                           input int stall, input logic [2:0] way, input logic dirty);
        chk("miss_ready_idle", miss_ready, 1);
        miss_valid = 1'b1; miss_index = idx; miss_tag = tag; rdata = rd;
        wb_ready = 1'b0; fill_ready = 1'b1;
        @(posedge clock); #1 miss_valid = 1'b0; miss_index = '0; miss_tag = '0;
        @(negedge clock);                              // T+1
        chk("rd_valid", dv, 1);
        chk("rd_index", di, idx);
        chk("miss_ready_busy", miss_ready, 0);
        @(negedge clock);                              // T+2
        chk("rd_strobe_1cyc", dv, 0);
        chk("rd_release", dr, 1);
        @(negedge clock);                              // T+3
        if (dirty) begin
            chk("wb_valid", wb_valid, 1);
            chk("wb_index", wb_index, idx);
            chk("wb_way", wb_way, way);
            chk("fill_before_wb", fill_valid, 0);
            for (int k = 0; k < stall; k++) begin
                @(negedge clock);
                chk("wb_hold_valid", wb_valid, 1);
                chk("wb_hold_index", wb_index, idx);
                chk("wb_hold_way", wb_way, way);
                chk("wb_hold_fill", fill_valid, 0);
                chk("wb_hold_busy", busy, 1);
                chk("wb_hold_mready", miss_ready, 0);
            end
            wb_ready = 1'b1;
            @(negedge clock);
            chk("wb_dropped", wb_valid, 0);
        end else begin
            chk("no_wb", wb_valid, 0);
        end
        chk("fill_valid", fill_valid, 1);
        chk("fill_index", fill_index, idx);
        chk("fill_way", fill_way, way);
        chk("fill_tag", fill_tag, tag);
        @(negedge clock);
        chk("fill_done", fill_valid, 0);
        chk("idle_again", miss_ready, 1);
        chk("not_busy", busy, 0);
        wb_ready = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [19:0] tag;
        logic [7:0]  rd;
        int          stall;
        logic [2:0]  way;
        logic        dirty;
    } vec_t;

    vec_t vecs [9];

`ifdef DCACHE_REPLACE_PLRU_EN
    localparam logic [7:0] c_RST_RD  = 8'h01;
    localparam logic [2:0] c_RST_WAY = 3'd0;
`else
    localparam logic [7:0] c_RST_RD  = 8'h02;
    localparam logic [2:0] c_RST_WAY = 3'd1;
`endif

    initial begin
        vecs[0] = '{6'd5,  20'h01234, 8'h00, 0, 3'd0, 1'b0};
        vecs[1] = '{6'd9,  20'hABCDE, 8'h02, 0, 3'd1, 1'b1};
        vecs[2] = '{6'd63, 20'hFFFFF, 8'h04, 3, 3'd2, 1'b1};
        vecs[3] = '{6'd0,  20'h00000, 8'hF7, 0, 3'd3, 1'b0};
        vecs[4] = '{6'd17, 20'h55555, 8'hFF, 1, 3'd4, 1'b1};
        vecs[5] = '{6'd2,  20'h0BEEF, 8'hDF, 0, 3'd5, 1'b0};
        vecs[6] = '{6'd40, 20'h12345, 8'h40, 0, 3'd6, 1'b1};
        vecs[7] = '{6'd41, 20'hFEDCB, 8'h7F, 0, 3'd7, 1'b0};
        vecs[8] = '{6'd42, 20'h00001, 8'h01, 0, 3'd0, 1'b1};

        reset = 1'b1; miss_valid = 1'b0; miss_index = '0; miss_tag = '0; rdata = '0;
        wb_ready = 1'b0; fill_ready = 1'b1;
        hit_valid = 1'b0; hit_index = '0; hit_way = '0;
        repeat (2) @(negedge clock);
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {dv, dr, wb_valid, fill_valid}, 0);
        chk("rst_fill_tag", fill_tag, 0);
        reset = 1'b0;
        @(negedge clock);

`ifdef DCACHE_REPLACE_PLRU_EN
        hit_valid = 1'b1; hit_index = 6'd3; hit_way = 3'd0;
        @(negedge clock);
        hit_valid = 1'b0;
        do_miss(6'd3, 20'h00AAA, 8'h00, 0, 3'd4, 1'b0);
        do_miss(6'd3, 20'h00BBB, 8'h00, 0, 3'd2, 1'b0);
`else
        for (int i = 0; i < 9; i++)
            do_miss(vecs[i].idx, vecs[i].tag, vecs[i].rd, vecs[i].stall, vecs[i].way, vecs[i].dirty);
`endif

        // Reset while a writeback request is pending.
        miss_valid = 1'b1; miss_index = 6'd7; miss_tag = 20'h77777; rdata = c_RST_RD;
        wb_ready = 1'b0;
        @(posedge clock); #1 miss_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_rst_wb_valid", wb_valid, 1);
        chk("pre_rst_wb_way", wb_way, c_RST_WAY);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_fill_valid", fill_valid, 0);
        chk("mid_rst_miss_ready", miss_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wb_index", wb_index, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

`ifdef DCACHE_REPLACE_PLRU_EN
        do_miss(6'd7, 20'h77777, 8'h00, 0, 3'd0, 1'b0);
`else
        for (int i = 0; i < 9; i++)
            do_miss(6'(i + 20), 20'(32'h100 + i), 8'h00, 0, 3'(i % 8), 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
